game_referee: RTL

Turn sequencer and judge for the two-player fighting game. It generates the paced `actionEnable` strobe consumed by both player blocks. After every turn it samples their `health` outputs and decides knock-out, turn-limit and winner. It drives `isGameOver` back to the players and to the display logic.

---
 rtl/game_referee.sv | 116 +++++++++++
 1 files changed

// File: rtl/game_referee.sv
// Turn sequencer and judge for the two-player fighting game: paces the actionEnable
// strobe, samples both health values once per turn and decides KO / turn-limit winner.
module game_referee #(
  parameter int TURN_PERIOD = 8,
  parameter int PULSE_LEN   = 2,
  parameter int MAX_TURNS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] health1,
  input  logic [1:0] health2,
  output logic       actionEnable,
  output logic       isGameOver,
  output logic [1:0] winner,
  output logic [7:0] turnCount
);

  localparam int GAP_LEN = TURN_PERIOD - PULSE_LEN - 1;
  localparam int CW      = $clog2(TURN_PERIOD + 1);
  localparam logic [CW-1:0] ARM_LAST   = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);
  localparam logic [7:0]    TURN_LIMIT = 8'(MAX_TURNS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_GAP,
    S_OVER
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_prev1;
  logic [1:0]    r_prev2;
  logic          r_action;
  logic          r_over;
  logic [1:0]    r_winner;
  logic [7:0]    r_turns;

  logic          w_ko1;
  logic          w_ko2;
  logic          w_decided;
  logic [1:0]    w_win;
  logic [7:0]    w_turns_inc;

  // A jump from 1 to 3 is the 2-bit wrap of a -2 hit, so it counts as a knock-out.
  always_comb begin
    w_ko1       = (health1 == 2'd0) || ((r_prev1 == 2'd1) && (health1 == 2'd3));
    w_ko2       = (health2 == 2'd0) || ((r_prev2 == 2'd1) && (health2 == 2'd3));
    w_turns_inc = r_turns + 8'd1;
    w_decided   = 1'b1;
    w_win       = 2'b00;
    if (w_ko1 && w_ko2) begin
      w_win = 2'b11;
    end else if (w_ko1) begin
      w_win = 2'b10;
    end else if (w_ko2) begin
      w_win = 2'b01;
    end else if (w_turns_inc == TURN_LIMIT) begin
      if (health1 > health2)      w_win = 2'b01;
      else if (health2 > health1) w_win = 2'b10;
      else                        w_win = 2'b11;
    end else begin
      w_decided = 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ARM;
      S_ARM:    if (r_cnt == ARM_LAST) w_next = S_SETTLE;
      S_SETTLE: w_next = w_decided ? S_OVER : S_GAP;
      S_GAP:    if (r_cnt == GAP_LAST) w_next = S_ARM;
      S_OVER:   w_next = S_OVER;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prev1  <= 2'd3;
      r_prev2  <= 2'd3;
      r_action <= 1'b0;
      r_over   <= 1'b0;
      r_winner <= 2'b00;
      r_turns  <= 8'd0;
    end else begin
      r_state  <= w_next;
      // The strobe is registered from the next state so it is high exactly while in ARM.
      r_action <= (w_next == S_ARM);
      r_cnt    <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      if (r_state == S_SETTLE) begin
        r_turns <= w_turns_inc;
        if (w_decided) begin
          r_winner <= w_win;
          r_over   <= 1'b1;
        end else begin
          r_prev1 <= health1;
          r_prev2 <= health2;
        end
      end
    end
  end

  assign actionEnable = r_action;
  assign isGameOver   = r_over;
  assign winner       = r_winner;
  assign turnCount    = r_turns;

endmodule
